// File: rtl/fp_pkg.sv
// Shared FPU package: binary32 field layout, canonical constants and the
// fp_sqrt controller state encoding.
// The NORM state exists only when FP_SQRT_DENORM_EN is defined.
package fp_pkg;

  localparam logic [31:0] FP_CANON_NAN = 32'h7fc00000;
  localparam int          FP_BIAS      = 127;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
`ifdef FP_SQRT_DENORM_EN
    S_NORM,
`endif
    S_CALC,
    S_ROUND,
    S_DONE
  } fp_sqrt_state_t;

endpackage

// File: rtl/fp_sqrt_if.sv
// FPU unit handshake bundle for the square-root slot.
//   en_n    : active-low request/hold from the dispatcher
//   a       : binary32 operand, sampled on the start edge
//   result  : binary32 result, valid while out_stb=1
//   out_stb : result valid, held until en_n returns high
//   busy    : unit is working (not IDLE, not DONE)
interface fp_sqrt_if;
  logic        en_n;
  logic [31:0] a;
  logic [31:0] result;
  logic        out_stb;
  logic        busy;

  modport master (output en_n, a, input  result, out_stb, busy);
  modport slave  (input  en_n, a, output result, out_stb, busy);
endinterface

// File: rtl/fp_lzc24.sv
// 24-bit leading-zero counter, combinational. Returns 24 for an all-zero
// input. Only built when FP_SQRT_DENORM_EN is defined (subnormal
// normalisation is its sole user).
//   d_i   : value to scan
//   cnt_o : number of leading zeros
`ifdef FP_SQRT_DENORM_EN
module fp_lzc24 (
  input  logic [23:0] d_i,
  output logic [4:0]  cnt_o
);
  // Scan upward so the highest set bit has the final say.
  always_comb begin
    cnt_o = 5'd24;
    for (int i = 0; i < 24; i++)
      if (d_i[i]) cnt_o = 5'(23 - i);
  end
endmodule
`endif

// File: rtl/fp_sqrt.sv
// Iterative binary32 square root (FSQRT.S slot), round-to-nearest-even.
// Restoring digit-by-digit root over a 52-bit radicand, BITS_PER_CYCLE
// (1 or 2) root bits per CALC cycle.
//   g_clk, g_rst : clock, synchronous active-high reset
//   bus          : fp_sqrt_if slave (en_n, a, result, out_stb, busy)
// Macro FP_SQRT_DENORM_EN: subnormal inputs are normalised in a one-cycle
// NORM state; when undefined they flush to a signed zero.
module fp_sqrt
  import fp_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input logic      g_clk,
  input logic      g_rst,
  fp_sqrt_if.slave bus
);

  localparam int         CALC_ITERS = 26 / BITS_PER_CYCLE;
  localparam logic [4:0] CNT_LAST   = 5'(CALC_ITERS - 1);

  fp_sqrt_state_t    state_q, state_d;
  fp32_t             a_q, a_d;
  logic [25:0]       q_q, q_d;
  logic [27:0]       rem_q, rem_d;
  logic [51:0]       rad_q, rad_d;
  logic [4:0]        cnt_q, cnt_d;
  logic signed [9:0] exp_q, exp_d;   // even unbiased exponent e'
  logic [31:0]       res_q, res_d;

  // Operand classification
  logic is_nan, is_inf, is_zero, is_sub;
  assign is_nan  = (&a_q.exp) &  (|a_q.frac);
  assign is_inf  = (&a_q.exp) & ~(|a_q.frac);
  assign is_zero = ~(|a_q.exp) & ~(|a_q.frac);
  assign is_sub  = ~(|a_q.exp) &  (|a_q.frac);

  // Mantissa/exponent preparation, shared by UNPACK and NORM
  logic [23:0]       m_sel;
  logic signed [9:0] e_sel, e_even;
  logic [24:0]       m_adj;

`ifdef FP_SQRT_DENORM_EN
  logic [4:0] lz;
  // Trailing 0 pad: frac is nonzero here, so the count is the zero run of frac.
  fp_lzc24 u_lzc (.d_i({a_q.frac, 1'b0}), .cnt_o(lz));
`endif

  always_comb begin
    m_sel = {1'b1, a_q.frac};
    e_sel = $signed({2'b00, a_q.exp}) - $signed(10'(FP_BIAS));
`ifdef FP_SQRT_DENORM_EN
    if (state_q == S_NORM) begin
      m_sel = {1'b0, a_q.frac} << (lz + 5'd1);
      e_sel = -10'sd127 - $signed({5'b00000, lz});
    end
`endif
    // Odd exponent: fold one factor of two into the mantissa so e' halves exactly.
    m_adj  = e_sel[0] ? {m_sel, 1'b0} : {1'b0, m_sel};
    e_even = {e_sel[9:1], 1'b0};
  end

  // Root iteration(s) for one CALC cycle
  logic [25:0] q_nx;
  logic [27:0] rem_nx;
  logic [51:0] rad_nx;
  logic [29:0] t, trial;

  always_comb begin
    q_nx   = q_q;
    rem_nx = rem_q;
    rad_nx = rad_q;
    t      = '0;
    trial  = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      t     = {rem_nx, rad_nx[51:50]};
      trial = {2'b00, q_nx, 2'b01};
      if (t >= trial) begin
        rem_nx = 28'(t - trial);
        q_nx   = {q_nx[24:0], 1'b1};
      end else begin
        rem_nx = t[27:0];
        q_nx   = {q_nx[24:0], 1'b0};
      end
      rad_nx = {rad_nx[49:0], 2'b00};
    end
  end

  // Rounding: q[25] is the hidden bit, q[24:2] the fraction, q[1] guard.
  logic        rnd_up;
  logic [23:0] frac_sum;   // {carry, fraction}
  logic [7:0]  exp_out;

  always_comb begin
    rnd_up   = q_q[1] & (q_q[0] | (|rem_q) | q_q[2]);
    frac_sum = {1'b0, q_q[24:2]} + {23'b0, rnd_up};
    // A carry leaves the fraction at zero and bumps the exponent.
    exp_out  = 8'(exp_q >>> 1) + 8'(FP_BIAS) + {7'b0, frac_sum[23]};
  end

  // Controller
  logic load;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    rem_d   = rem_q;
    rad_d   = rad_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    res_d   = res_q;
    load    = 1'b0;

    case (state_q)
      S_IDLE:
        if (!bus.en_n) begin
          a_d     = bus.a;
          state_d = S_UNPACK;
        end
      S_UNPACK:
        if (bus.en_n) state_d = S_IDLE;
        else if (is_nan)  begin res_d = FP_CANON_NAN;       state_d = S_DONE; end
        else if (is_zero) begin res_d = {a_q.sign, 31'b0};  state_d = S_DONE; end
`ifndef FP_SQRT_DENORM_EN
        else if (is_sub)  begin res_d = {a_q.sign, 31'b0};  state_d = S_DONE; end
`endif
        else if (a_q.sign) begin res_d = FP_CANON_NAN;      state_d = S_DONE; end
        else if (is_inf)  begin res_d = 32'h7f800000;       state_d = S_DONE; end
`ifdef FP_SQRT_DENORM_EN
        else if (is_sub)  state_d = S_NORM;
`endif
        else load = 1'b1;
`ifdef FP_SQRT_DENORM_EN
      S_NORM:
        if (bus.en_n) state_d = S_IDLE;
        else          load = 1'b1;
`endif
      S_CALC:
        if (bus.en_n) state_d = S_IDLE;
        else begin
          q_d   = q_nx;
          rem_d = rem_nx;
          rad_d = rad_nx;
          cnt_d = cnt_q - 5'd1;
          if (cnt_q == 5'd0) state_d = S_ROUND;
        end
      S_ROUND:
        if (bus.en_n) state_d = S_IDLE;
        else begin
          res_d   = {1'b0, exp_out, frac_sum[22:0]};
          state_d = S_DONE;
        end
      S_DONE:
        if (bus.en_n) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Radicand = M << 27 gives a 26-bit root: 24 result bits + guard + sticky.
    if (load) begin
      rad_d   = {m_adj, 27'b0};
      exp_d   = e_even;
      q_d     = '0;
      rem_d   = '0;
      cnt_d   = CNT_LAST;
      state_d = S_CALC;
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      q_q     <= '0;
      rem_q   <= '0;
      rad_q   <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      rem_q   <= rem_d;
      rad_q   <= rad_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      res_q   <= res_d;
    end
  end

  assign bus.result  = res_q;
  assign bus.out_stb = (state_q == S_DONE);
  assign bus.busy    = (state_q != S_IDLE) && (state_q != S_DONE);

endmodule

// File: tb/tb_fp_sqrt.sv
// Scoreboard bench for fp_sqrt: the driver pushes the expected result and
// the cycle at which out_stb must rise; a negedge monitor pops and compares
// on each out_stb rising edge.
module tb_fp_sqrt;

  localparam int BPC   = 1;
  localparam int LAT_N = 2 + 26 / BPC;
  localparam int LAT_S = 1;
`ifdef FP_SQRT_DENORM_EN
  localparam int          LAT_D = LAT_N + 1;
  localparam logic [31:0] EXP_D = 32'h1a3504f3;
`else
  localparam int          LAT_D = LAT_S;
  localparam logic [31:0] EXP_D = 32'h00000000;
`endif

  logic g_clk = 1'b0;
  logic g_rst;

  fp_sqrt_if bif ();

  fp_sqrt #(.BITS_PER_CYCLE(BPC)) dut (
    .g_clk (g_clk),
    .g_rst (g_rst),
    .bus   (bif)
  );

  always #5 g_clk = ~g_clk;

  int cyc = 0;
  always @(posedge g_clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] res;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] last_res;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Monitor
  logic stb_prev = 1'b0;
  always @(negedge g_clk) begin : mon
    exp_t e;
    if (!g_rst && bif.out_stb && !stb_prev) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_stb: got result %h expected no strobe", bif.result);
      end else begin
        e = sb.pop_front();
        chk($sformatf("result a=%h", e.a), bif.result, e.res);
        chk($sformatf("latency a=%h", e.a), 32'(cyc), 32'(e.due));
      end
    end
    stb_prev <= bif.out_stb;
  end

  // One full request: expected pushed at issue, held `hold` extra cycles.
  task automatic run(input logic [31:0] a, input logic [31:0] res, input int lat,
                     input int hold);
    int n;
    @(negedge g_clk);
    bif.a    = a;
    bif.en_n = 1'b0;
    sb.push_back('{a: a, res: res, due: cyc + 1 + lat});
    @(negedge g_clk);
    bif.a = ~a;   // must be ignored after the start edge
    n = 0;
    while (!bif.out_stb && n < 200) begin
      @(negedge g_clk);
      n++;
    end
    if (!bif.out_stb) begin
      checks++;
      errors++;
      $display("FAIL timeout a=%h: got no out_stb expected strobe", a);
      if (sb.size() != 0) void'(sb.pop_front());
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge g_clk);
      chk("hold_out_stb", bif.out_stb, 1);
      chk("hold_result", bif.result, res);
    end
    last_res = res;
    bif.en_n = 1'b1;
    @(negedge g_clk);
    chk("release_out_stb", bif.out_stb, 0);
    chk("release_busy", bif.busy, 0);
  endtask

  initial begin
    g_rst    = 1'b1;
    bif.en_n = 1'b1;
    bif.a    = '0;
    last_res = '0;
    repeat (3) @(negedge g_clk);
    chk("reset_result", bif.result, 0);
    chk("reset_out_stb", bif.out_stb, 0);
    chk("reset_busy", bif.busy, 0);
    g_rst = 1'b0;

    // Normal operands (first one also checks hold stability)
    run(32'h40800000, 32'h40000000, LAT_N, 5);
    run(32'h41100000, 32'h40400000, LAT_N, 0);
    run(32'h40000000, 32'h3fb504f3, LAT_N, 0);
    run(32'h3f800000, 32'h3f800000, LAT_N, 0);
    run(32'h40a00000, 32'h400f1bbd, LAT_N, 0);   // rounds up
    run(32'h40400000, 32'h3fddb3d7, LAT_N, 0);   // rounds down

    // Specials
    run(32'hc0800000, 32'h7fc00000, LAT_S, 0);
    run(32'h7fc00001, 32'h7fc00000, LAT_S, 0);
    run(32'h80000000, 32'h80000000, LAT_S, 0);
    run(32'h7f800000, 32'h7f800000, LAT_S, 0);
    run(32'hff800000, 32'h7fc00000, LAT_S, 0);
    run(32'h00000000, 32'h00000000, LAT_S, 0);

    // Smallest subnormal
    run(32'h00000001, EXP_D, LAT_D, 0);

    // Cancel at CALC iteration 10
    @(negedge g_clk);
    bif.a    = 32'h40800000;
    bif.en_n = 1'b0;
    repeat (11) @(negedge g_clk);
    chk("cancel_busy_before", bif.busy, 1);
    bif.en_n = 1'b1;
    @(negedge g_clk);
    chk("cancel_busy", bif.busy, 0);
    chk("cancel_out_stb", bif.out_stb, 0);
    chk("cancel_result_kept", bif.result, last_res);
    repeat (3) @(negedge g_clk);
    chk("cancel_no_stb", bif.out_stb, 0);
    run(32'h40800000, 32'h40000000, LAT_N, 0);

    // Reset mid-CALC
    @(negedge g_clk);
    bif.a    = 32'h41100000;
    bif.en_n = 1'b0;
    repeat (8) @(negedge g_clk);
    g_rst    = 1'b1;
    bif.en_n = 1'b1;
    @(negedge g_clk);
    chk("midrst_result", bif.result, 0);
    chk("midrst_out_stb", bif.out_stb, 0);
    chk("midrst_busy", bif.busy, 0);
    g_rst = 1'b0;
    run(32'h41100000, 32'h40400000, LAT_N, 0);

    repeat (5) @(negedge g_clk);
    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: got no completion expected finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
